// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word geometry and the sequencer state
// encoding, common to the TX/RX sequencers and the serializer.
package spi_pkg;

  localparam int SPI_WORD_W = 16;
  localparam int SPI_IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Width of a counter that must reach max(a, b, c) - 1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// SCLK half-period timer: counts 0..DIV-1 and flags each wrap as the
// rising or falling SCLK edge that is about to be registered.
module spi_clk_tick #(
  parameter int DIV   = 4,
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic rise_tick,
  output logic fall_tick
);

  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;  // 0: the next wrap produces a rising edge
  logic             wrap;

  assign wrap      = en && (cnt_q == CNT_W'(DIV - 1));
  assign rise_tick = wrap && !phase_q;
  assign fall_tick = wrap && phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (clr) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_tx_ctrl.sv
// SPI transmit sequencer: accepts a word, holds it for the serializer and
// drives serializer enable/index, SCLK (mode 0) and CS_n framing.
module spi_tx_ctrl
  import spi_pkg::*;
#(
  parameter int WORD_W   = SPI_WORD_W,
  parameter int IDX_W    = SPI_IDX_W,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              FPGA_clk,
  input  logic              FPGA_rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [WORD_W-1:0] tx_data,
  output logic [WORD_W-1:0] pts_data,
  output logic              pts_en,
  output logic [IDX_W-1:0]  pts_index,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
);

  localparam int CNT_W = cnt_width(CLK_DIV, CS_SETUP, CS_HOLD);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("spi_tx_ctrl: CLK_DIV must be at least 1");
  end
  if (CS_SETUP < 1) begin : g_bad_setup
    $error("spi_tx_ctrl: CS_SETUP must be at least 1");
  end
  if (CS_HOLD < 1) begin : g_bad_hold
    $error("spi_tx_ctrl: CS_HOLD must be at least 1");
  end
  if (IDX_W != $clog2(WORD_W)) begin : g_bad_idx
    $error("spi_tx_ctrl: IDX_W must equal clog2(WORD_W)");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WORD_W-1:0]  data_q;
  logic               sclk_q, cs_n_q, en_q, done_q;
  logic               accept, rise_tick, fall_tick;

  // Handshake: a word transfers on a rising clock edge where tx_valid and
  // tx_ready are both high; tx_ready is high only in IDLE, so a word offered
  // while busy simply waits (it is neither taken nor dropped).
  assign accept    = tx_valid && (state_q == IDLE);
  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

  assign pts_data  = data_q;
  assign pts_index = idx_q;
  assign pts_en    = en_q;
  assign spi_sclk  = sclk_q;
  assign spi_cs_n  = cs_n_q;
  assign done      = done_q;

  spi_clk_tick #(
    .DIV   (CLK_DIV),
    .CNT_W (CNT_W)
  ) u_tick (
    .clk       (FPGA_clk),
    .rst_n     (FPGA_rst_n),
    .en        (state_q == SHIFT),
    .clr       (state_q != SHIFT),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (cnt_q == CNT_W'(CS_SETUP - 1)) state_d = SHIFT;
      SHIFT:   if (fall_tick && idx_q == '0) state_d = HOLD;
      HOLD:    if (cnt_q == CNT_W'(CS_HOLD - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge FPGA_clk or negedge FPGA_rst_n) begin
    if (!FPGA_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= IDX_W'(WORD_W - 1);
      data_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || state_q == IDLE || state_q == SHIFT)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CNT_W'(1);

      if (state_q == SHIFT && state_d == SHIFT) begin
        if (rise_tick)      sclk_q <= 1'b1;
        else if (fall_tick) sclk_q <= 1'b0;
      end else begin
        sclk_q <= 1'b0;
      end

      cs_n_q <= (state_d == IDLE);
      en_q   <= (state_d == SETUP) || (state_d == SHIFT);
      done_q <= (state_q == HOLD) && (state_d == IDLE);

      // Index moves only on falling edges and saturates at 0.
      if (accept) begin
        data_q <= tx_data;
        idx_q  <= IDX_W'(WORD_W - 1);
      end else if (state_q == SHIFT && fall_tick && idx_q != '0) begin
        idx_q <= idx_q - IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_tx_ctrl.sv
// Bench for spi_tx_ctrl: a default instance and a fast one (CLK_DIV=1,
// CS_SETUP=1, CS_HOLD=1), a serializer model feeding MOSI, and frame checks.
module tb_spi_tx_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tx_valid [2];
  logic [W-1:0] tx_data [2];
  logic         tx_ready [2];
  logic [W-1:0] pts_data [2];
  logic         pts_en [2];
  logic [3:0]   pts_index [2];
  logic         spi_sclk [2];
  logic         spi_cs_n [2];
  logic         busy [2];
  logic         done [2];
  logic [1:0]   fsm_state [2];
  logic         mosi [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_tx_ctrl u_dut_a (
    .FPGA_clk (clk), .FPGA_rst_n (rst_n),
    .tx_valid (tx_valid[0]), .tx_ready (tx_ready[0]), .tx_data (tx_data[0]),
    .pts_data (pts_data[0]), .pts_en (pts_en[0]), .pts_index (pts_index[0]),
    .spi_sclk (spi_sclk[0]), .spi_cs_n (spi_cs_n[0]), .busy (busy[0]),
    .done (done[0]), .fsm_state (fsm_state[0])
  );

  spi_tx_ctrl #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut_b (
    .FPGA_clk (clk), .FPGA_rst_n (rst_n),
    .tx_valid (tx_valid[1]), .tx_ready (tx_ready[1]), .tx_data (tx_data[1]),
    .pts_data (pts_data[1]), .pts_en (pts_en[1]), .pts_index (pts_index[1]),
    .spi_sclk (spi_sclk[1]), .spi_cs_n (spi_cs_n[1]), .busy (busy[1]),
    .done (done[1]), .fsm_state (fsm_state[1])
  );

  // Expected frame length straight from the framing rule:
  // setup + 2 half-periods per bit + hold.
  function automatic int exp_busy(input int s);
    int div, su, ho;
    div = (s == 0) ? 4 : 1;
    su  = (s == 0) ? 2 : 1;
    ho  = (s == 0) ? 2 : 1;
    return su + 2 * W * div + ho;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic       prev_cs_n = 1'b1;
    logic       prev_sclk = 1'b0;
    logic [3:0] prev_idx  = 4'd15;

    // Serializer: presents the selected bit one cycle after enable/index.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mosi[g] <= 1'b0;
      else        mosi[g] <= pts_en[g] ? pts_data[g][pts_index[g]] : 1'b0;
    end

    always @(negedge clk) begin
      checks++;
      if (spi_sclk[g] && spi_cs_n[g]) begin
        errors++;
        $display("FAIL sclk_while_cs_high dut%0d sclk=%b cs_n=%b required sclk=0",
                 g, spi_sclk[g], spi_cs_n[g]);
      end
      checks++;
      if (!prev_cs_n && !spi_cs_n[g] && prev_idx == 4'd0 && pts_index[g] == 4'd15) begin
        errors++;
        $display("FAIL index_wrap dut%0d index went 0 -> %0d inside frame, required to stay 0",
                 g, pts_index[g]);
      end
      if (spi_sclk[g] && !prev_sclk) begin
        checks++;
        if (pts_index[g] !== prev_idx) begin
          errors++;
          $display("FAIL index_on_rise dut%0d got %0d required %0d", g, pts_index[g], prev_idx);
        end
      end
      prev_cs_n = spi_cs_n[g];
      prev_sclk = spi_sclk[g];
      prev_idx  = pts_index[g];
    end
  end

  // One full frame on instance s: drive a 1-cycle valid pulse and compare
  // captured MOSI bits and timing with the expected frame.
  task automatic run_frame(input int s, input logic [W-1:0] word, input string name);
    int exp, cs_low, busy_cyc, done_cnt, done_at, nbits;
    logic [W-1:0] bits;
    logic prev_sclk;
    exp = exp_busy(s);
    cs_low = 0; busy_cyc = 0; done_cnt = 0; done_at = -1; nbits = 0;
    bits = '0; prev_sclk = 1'b0;
    @(negedge clk);
    tx_data[s]  = word;
    tx_valid[s] = 1'b1;
    for (int cyc = 1; cyc <= exp + 4; cyc++) begin
      @(negedge clk);
      tx_valid[s] = 1'b0;
      if (!spi_cs_n[s]) cs_low++;
      if (busy[s]) busy_cyc++;
      if (done[s]) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (spi_sclk[s] && !prev_sclk) begin
        bits = {bits[W-2:0], mosi[s]};
        nbits++;
      end
      prev_sclk = spi_sclk[s];
    end
    checks++;
    if (nbits != W) begin
      errors++;
      $display("FAIL %s_edges dut%0d got %0d required %0d", name, s, nbits, W);
    end
    checks++;
    if (bits !== word) begin
      errors++;
      $display("FAIL %s_bits dut%0d got %b required %b", name, s, bits, word);
    end
    checks++;
    if (cs_low != exp) begin
      errors++;
      $display("FAIL %s_cs_low dut%0d got %0d required %0d", name, s, cs_low, exp);
    end
    checks++;
    if (busy_cyc != exp) begin
      errors++;
      $display("FAIL %s_busy dut%0d got %0d required %0d", name, s, busy_cyc, exp);
    end
    checks++;
    if (done_cnt != 1 || done_at != exp + 1) begin
      errors++;
      $display("FAIL %s_done dut%0d got count=%0d at=%0d required count=1 at=%0d",
               name, s, done_cnt, done_at, exp + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tx_valid[s] = 1'b0;
      tx_data[s]  = '0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (spi_cs_n[s] !== 1'b1 || spi_sclk[s] !== 1'b0 || pts_en[s] !== 1'b0 ||
          busy[s] !== 1'b0 || done[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d cs_n=%b sclk=%b en=%b busy=%b done=%b required 1 0 0 0 0",
                 s, spi_cs_n[s], spi_sclk[s], pts_en[s], busy[s], done[s]);
      end
      checks++;
      if (pts_index[s] !== 4'd15 || pts_data[s] !== '0) begin
        errors++;
        $display("FAIL reset_data dut%0d index=%0d data=%h required 15 0000",
                 s, pts_index[s], pts_data[s]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (tx_ready[s] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready dut%0d got %b required 1", s, tx_ready[s]);
      end
    end
  endtask

  task automatic test_fixed_word();
    run_frame(0, 16'hA5C3, "a5c3_default");
    run_frame(1, 16'hA5C3, "a5c3_fast");
  endtask

  task automatic test_random_words();
    for (int i = 0; i < 3; i++) begin
      run_frame(0, W'($urandom), "rand_default");
      run_frame(1, W'($urandom), "rand_fast");
    end
  endtask

  task automatic test_back_to_back();
    int phase, gap, rises1, rises2, done_cnt;
    logic [W-1:0] bits1, bits2;
    logic prev_sclk, drop_next, c;
    phase = 0; gap = 0; rises1 = 0; rises2 = 0; done_cnt = 0;
    bits1 = '0; bits2 = '0; prev_sclk = 1'b0; drop_next = 1'b0;
    @(negedge clk);
    tx_data[0]  = 16'hFFFF;
    tx_valid[0] = 1'b1;
    for (int cyc = 1; cyc <= 2 * exp_busy(0) + 12; cyc++) begin
      @(negedge clk);
      tx_data[0] = 16'h0001;
      c = spi_cs_n[0];
      if (drop_next) tx_valid[0] = 1'b0;
      if (done[0]) begin
        done_cnt++;
        drop_next = 1'b1;
      end
      case (phase)
        0: if (!c) phase = 1;
        1: if (c) begin phase = 2; gap = 1; end
        2: if (c) gap++; else phase = 3;
        3: if (c) phase = 4;
        default: ;
      endcase
      if (spi_sclk[0] && !prev_sclk) begin
        if (phase == 1) begin bits1 = {bits1[W-2:0], mosi[0]}; rises1++; end
        if (phase == 3) begin bits2 = {bits2[W-2:0], mosi[0]}; rises2++; end
      end
      prev_sclk = spi_sclk[0];
    end
    tx_valid[0] = 1'b0;
    checks++;
    if (phase != 4 || gap != 1) begin
      errors++;
      $display("FAIL b2b_gap got phase=%0d gap=%0d required phase=4 gap=1", phase, gap);
    end
    checks++;
    if (rises1 != W || bits1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL b2b_frame1 got %0d edges %b required 16 edges %b", rises1, bits1, 16'hFFFF);
    end
    checks++;
    if (rises2 != W || bits2 !== 16'h0001) begin
      errors++;
      $display("FAIL b2b_frame2 got %0d edges %b required 16 edges %b", rises2, bits2, 16'h0001);
    end
    checks++;
    if (done_cnt != 2) begin
      errors++;
      $display("FAIL b2b_done got %0d required 2", done_cnt);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int falls, done_cnt;
    logic prev_sclk, hit;
    falls = 0; done_cnt = 0; prev_sclk = 1'b0; hit = 1'b0;
    @(negedge clk);
    tx_data[0]  = W'($urandom);
    tx_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
      @(negedge clk);
      tx_valid[0] = 1'b0;
      if (!spi_sclk[0] && prev_sclk) falls++;
      prev_sclk = spi_sclk[0];
      if (falls == 8) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midrst_timeout got %0d falling edges required 8", falls);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (spi_cs_n[0] !== 1'b1 || spi_sclk[0] !== 1'b0 || pts_en[0] !== 1'b0 ||
        pts_index[0] !== 4'd15 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs cs_n=%b sclk=%b en=%b index=%0d busy=%b required 1 0 0 15 0",
               spi_cs_n[0], spi_sclk[0], pts_en[0], pts_index[0], busy[0]);
    end
    repeat (2) begin
      @(negedge clk);
      if (done[0]) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done[0]) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL midrst_done got %0d pulses required 0", done_cnt);
    end
    run_frame(0, W'($urandom), "post_reset");
  endtask

  task automatic test_data_hold();
    int ready_low;
    logic seen;
    logic [W-1:0] word;
    ready_low = 0; seen = 1'b0;
    word = W'($urandom);
    @(negedge clk);
    tx_data[0]  = word;
    tx_valid[0] = 1'b1;
    for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
      @(negedge clk);
      checks++;
      if (pts_data[0] !== word) begin
        errors++;
        $display("FAIL hold_data cycle %0d got %h required %h", cyc, pts_data[0], word);
      end
      if (tx_ready[0]) begin
        seen = 1'b1;
        tx_valid[0] = 1'b0;
      end else begin
        ready_low++;
        tx_data[0]  = W'($urandom);
        tx_valid[0] = 1'b1;
      end
    end
    checks++;
    if (!seen || ready_low != exp_busy(0)) begin
      errors++;
      $display("FAIL hold_ready_low got %0d cycles required %0d", ready_low, exp_busy(0));
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_accept got busy=%b required 0", busy[0]);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_word();
    test_random_words();
    test_back_to_back();
    test_reset_mid_transfer();
    test_data_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_tx_ctrl.md
Name: spi_tx_ctrl

Overview:
Sequencer for the SPI transmit path. It accepts a 16-bit word over a valid/ready handshake and holds it stable for the downstream parallel-to-serial stage. It drives that stage's enable and bit index, MSB first, and generates the SPI SCLK and CS_n with programmable clock division and chip-select setup/hold. The stage's serial output goes directly to MOSI.

Parameters:
WORD_W, 16, word width; must match the serializer.
IDX_W, 4, index width; equals clog2(WORD_W).
CLK_DIV, 4, FPGA_clk cycles per SCLK half-period; must be at least 1.
CS_SETUP, 2, cycles from CS_n falling to the first SCLK edge; must be at least 1, to cover the serializer's 1-cycle load.
CS_HOLD, 2, cycles from the last SCLK falling edge to CS_n rising; must be at least 1.

Ports:
FPGA_clk  in  1  system clock; all logic on the rising edge.
FPGA_rst_n  in  1  asynchronous, active-low reset.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  high only in IDLE; a word is accepted when tx_valid and tx_ready are both high.
tx_data  in  WORD_W  word to transmit.
pts_data  out  WORD_W  latched word, held stable from accept until the next accept.
pts_en  out  1  serializer enable.
pts_index  out  IDX_W  bit select for the serializer.
spi_sclk  out  1  SPI clock, mode 0 (idles low).
spi_cs_n  out  1  chip select, active low.
busy  out  1  high in any state other than IDLE.
done  out  1  1-cycle pulse when a transaction completes.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state IDLE; spi_sclk 0; spi_cs_n 1; pts_en 0; pts_index WORD_W-1; pts_data 0; busy 0; done 0.
  - tx_ready becomes 1 once reset is released.
- All outputs are registered; tx_ready and busy are decoded from the registered state.
- IDLE:
  - spi_cs_n 1, spi_sclk 0, pts_en 0.
  - On accept: latch tx_data into pts_data, set pts_index to WORD_W-1, go to SETUP.
  - tx_valid while busy is ignored; the word is not lost, because tx_ready stays low until IDLE.
- SETUP, lasting CS_SETUP cycles:
  - spi_cs_n 0, pts_en 1, spi_sclk 0.
  - The serializer loads pts_data during the first SETUP cycle, so MOSI carries bit 15 before the first rising edge.
  - Go to SHIFT.
- SHIFT:
  - A half-period counter runs 0 to CLK_DIV-1; spi_sclk toggles on each wrap.
  - Rising edges are the slave sample points; pts_index does not change on them.
  - On each falling edge: if pts_index is above 0, decrement it; otherwise go to HOLD.
  - pts_index saturates at 0 and never wraps to WORD_W-1 within a transaction.
  - SHIFT lasts exactly 2*WORD_W*CLK_DIV cycles: 128 with the defaults, giving 16 rising edges.
- HOLD, lasting CS_HOLD cycles:
  - spi_sclk 0, pts_en 0 (MOSI returns to 0), spi_cs_n 0.
  - Then go to IDLE, with spi_cs_n 1 and done 1 in that first IDLE cycle.
- Back-to-back transactions:
  - A word may be accepted in the same cycle done is high.
  - spi_cs_n is then high for exactly 1 cycle between frames.
- Total transaction time:
  - Busy for CS_SETUP + 2*WORD_W*CLK_DIV + CS_HOLD cycles after the accept edge: 132 with the defaults.
  - Accept-to-done is that figure + 1.
- Invariants:
  - spi_sclk is never high while spi_cs_n is high.
  - pts_index is stable across every rising SCLK edge.
- Counters are sized from the maximum of CLK_DIV, CS_SETUP and CS_HOLD. Invalid parameter values raise an elaboration-time $error.

Decomposition:
- Shared package spi_pkg:
  - state enum {IDLE, SETUP, SHIFT, HOLD}, 2 bits;
  - WORD_W and IDX_W defaults, shared with the serializer and the future RX path.
- One sub-module, spi_clk_tick: a half-period counter emitting rise_tick and fall_tick, with an enable and a synchronous clear. It is reused by the RX sequencer.
- FSM, index counter and data latch stay in spi_tx_ctrl.

Test Plan:
- Reset, then tx_data=16'hA5C3 with tx_valid pulsed for 1 cycle, defaults. The bench captures MOSI from the serializer on rising SCLK edges and requires:
  - 16 edges, bits 1010010111000011;
  - spi_cs_n low for 132 cycles;
  - done pulsed once.
- Same word with CLK_DIV=1, CS_SETUP=1, CS_HOLD=1 -> SCLK period 2 cycles; busy for 1+32+1=34 cycles; data identical.
- tx_valid held high with words 16'hFFFF then 16'h0001 -> second accept in the done cycle; spi_cs_n high for exactly 1 cycle; second frame reads 0000000000000001.
- FPGA_rst_n pulled low at the 8th falling edge of a transfer -> spi_cs_n 1, spi_sclk 0, pts_en 0 and pts_index 15 immediately, no done pulse; a new word is accepted after release.
- tx_data changes every cycle during a transfer -> pts_data stays at the accepted value and tx_ready stays 0 until IDLE.
- Assertions run across all tests:
  - pts_index is never observed going from 0 to 15 during SHIFT;
  - spi_sclk is never 1 while spi_cs_n is 1.
